instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, output buffer entries, power of two and at least 2.
REQ-002 Parameter ADDR_STEP, default 4, byte increment of out_addr per emitted word.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  loads base_addr into address counter, clears counters and error flag.
REQ-006 base_addr  input  32  first instruction address.
REQ-007 in_valid  input  1  field tuple present.
REQ-008 in_ready  output  1  tuple accepted when in_valid and in_ready are both high.
REQ-009 fmt  input  3  format: R=0, I=1, S=2, B=3, U=4, J=5; 6 and 7 are illegal.
REQ-010 opcode  input  7; rd  input  5; funct3  input  3; rs1  input  5; rs2  input  5; funct7  input  7  RV32 instruction fields.
REQ-011 imm  input  32  signed byte-offset or immediate value.
REQ-012 out_valid  output  1  encoded word available.
REQ-013 out_ready  input  1  consumer takes the word when out_valid and out_ready are both high.
REQ-014 out_instr  output  32  encoded instruction word.
REQ-015 out_addr  output  32  address tagged to out_instr.
REQ-016 imm_err  output  1  sticky flag: a tuple was rejected.
REQ-017 word_count  output  16  number of words pushed into the FIFO since start, wraps modulo 2^16.

Function
REQ-018 The field layout SHALL be the inverse of the field decoder: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
REQ-019 The R format SHALL use all fields and ignore imm.
REQ-020 The I format SHALL place imm[11:0] in bits 31:20 and ignore rs2 and funct7.
REQ-021 The S format SHALL place imm[11:5] in bits 31:25 and imm[4:0] in bits 11:7.
REQ-022 The B format SHALL place imm[12] in bit 31, imm[10:5] in bits 30:25, imm[4:1] in bits 11:8, and imm[11] in bit 7.
REQ-023 The U format SHALL place imm[31:12] in bits 31:12 and set bits 11:7 from rd.
REQ-024 The J format SHALL place imm[20] in bit 31, imm[10:1] in bits 30:21, imm[11] in bit 20, and imm[19:12] in bits 19:12.
REQ-025 A tuple SHALL be rejected when any of the following holds:
- I or S with imm outside -2048..2047.
- B with imm outside -4096..4094 or imm[0] set.
- J with imm outside -2^20..2^20-2 or imm[0] set.
- U with imm[11:0] nonzero.
- fmt illegal.
REQ-026 A rejected tuple SHALL still be consumed (handshake completes), SHALL push nothing, SHALL NOT advance the address or word_count, and SHALL set imm_err.
REQ-027 A legal accepted tuple SHALL be encoded and registered into the FIFO in the acceptance cycle, tagged with the current address; the address SHALL then advance by ADDR_STEP and word_count by 1.
REQ-028 Latency from acceptance to out_valid into an empty FIFO SHALL be exactly 1 cycle.
REQ-029 in_ready SHALL be high iff the FIFO is not full and start is low; a simultaneous pop SHALL NOT free a slot within the same cycle.
REQ-030 Simultaneous push and pop with the FIFO non-empty SHALL keep the occupancy unchanged.
REQ-031 Word order SHALL be preserved; out_instr and out_addr SHALL be held stable while out_valid is high and out_ready is low.
REQ-032 The address SHALL wrap modulo 2^32.
REQ-033 start SHALL flush the FIFO, so that out_valid is low on the next cycle.
REQ-034 start SHALL load the address from base_addr, clear word_count, and clear imm_err; start has priority over any input.

Reset
REQ-035 On rst, the FIFO SHALL be empty, out_valid 0, in_ready 1 from the next cycle, address 0, word_count 0, and imm_err 0.
REQ-036 rst mid-stream SHALL discard buffered words without emitting them, and rst SHALL override start.

Structure
REQ-037 The format codes and the opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR) SHALL live in a shared package, riscv_pkg, also used by the decoder side.
REQ-038 The output buffer SHALL be a sub-module sync_fifo, parameterised by width (64) and FIFO_DEPTH.
REQ-039 The encoder and range check SHALL be combinational logic in instr_encoder.

Verification
REQ-040 start with base_addr=0x100, then R tuple add x3,x1,x2 -> out_instr=0x002081B3, out_addr=0x100 one cycle later.
REQ-041 I tuple addi x5,x0,-1 -> 0xFFF00293; then B tuple beq x1,x2,imm=-4 -> 0xFE208EE3 at address +4.
REQ-042 I tuple with imm=2048 -> imm_err=1, no output, address unchanged, word_count unchanged.
REQ-043 Hold out_ready=0 and push 3 legal tuples -> in_ready=0 after 2 pushes; release -> words emitted in order with addresses 0x100, 0x104, 0x108.
REQ-044 Assert start while the FIFO holds 2 words -> out_valid=0 next cycle, word_count=0, imm_err cleared.
REQ-045 base_addr=0xFFFFFFFC with 2 legal tuples -> out_addr values 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : RV32 instruction-format codes, base opcodes and the
//                encoder output-buffer entry type. Shared by the encoder
//                and decoder sides.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

    // Instruction format selector; codes 6 and 7 are illegal
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // RV32I base opcodes
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    // One output-buffer entry: address tag in the upper half
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } enc_word_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with synchronous flush. Full/empty come
//                from wrap-bit pointers; read data is the head entry shown
//                combinationally (first-word fall-through).
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; flush empties the buffer without touching storage
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; data contents need no reset since pointers gate them
    always_ff @(posedge clk) begin
        if (w_push && !i_flush && !rst) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Packs RV32 field tuples into 32-bit instruction words,
//                range-checks immediates, tags each word with a running
//                address and buffers the result in a small FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        imm_err,
    output logic [15:0] word_count
);

    import riscv_pkg::*;

    localparam logic [31:0] c_ADDR_INC = 32'(ADDR_STEP);

    logic [31:0] r_addr;
    logic [15:0] r_word_count;
    logic        r_imm_err;

    logic [31:0] w_instr;
    logic        w_legal;
    logic        w_accept;
    logic        w_push;
    logic        w_full;
    logic        w_empty;
    logic        w_fit12;
    logic        w_fit13;
    logic        w_fit21;
    enc_word_t   w_wdata;
    enc_word_t   w_rdata;

    // Immediate fits an N-bit signed field when all bits above N-1 equal the sign
    assign w_fit12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign w_fit13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign w_fit21 = (&imm[31:20]) | ~(|imm[31:20]);

    // Field packing and legality check per format
    always_comb begin
        w_instr = '0;
        w_legal = 1'b0;
        case (fmt)
            FMT_R: begin
                w_instr = {funct7, rs2, rs1, funct3, rd, opcode};
                w_legal = 1'b1;
            end
            FMT_I: begin
                w_instr = {imm[11:0], rs1, funct3, rd, opcode};
                w_legal = w_fit12;
            end
            FMT_S: begin
                w_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                w_legal = w_fit12;
            end
            FMT_B: begin
                w_instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                           imm[4:1], imm[11], opcode};
                w_legal = w_fit13 && !imm[0];
            end
            FMT_U: begin
                w_instr = {imm[31:12], rd, opcode};
                w_legal = (imm[11:0] == 12'd0);
            end
            FMT_J: begin
                w_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                w_legal = w_fit21 && !imm[0];
            end
            default: begin
                w_instr = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    // Ready only looks at the registered full flag, so a same-cycle pop never frees a slot
    assign in_ready      = !w_full && !start;
    assign w_accept      = in_valid && in_ready;
    assign w_push        = w_accept && w_legal;
    assign w_wdata.addr  = r_addr;
    assign w_wdata.instr = w_instr;

    // Address, word counter and sticky error; rst beats start, start beats input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_word_count <= '0;
            r_imm_err    <= 1'b0;
        end else if (start) begin
            r_addr       <= base_addr;
            r_word_count <= '0;
            r_imm_err    <= 1'b0;
        end else if (w_accept) begin
            if (w_legal) begin
                r_addr       <= r_addr + c_ADDR_INC;
                r_word_count <= r_word_count + 16'd1;
            end else begin
                r_imm_err    <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(enc_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (start),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (out_ready),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid  = !w_empty;
    assign out_instr  = w_rdata.instr;
    assign out_addr   = w_rdata.addr;
    assign imm_err    = r_imm_err;
    assign word_count = r_word_count;

endmodule : instr_encoder
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Scoreboard bench for instr_encoder. Stimulus pushes the
//                hand-computed word and its address into a queue on
//                acceptance; a monitor compares the queue head against the
//                DUT whenever out_valid is high and pops on handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        imm_err;
    logic [15:0] word_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb [$];
    logic [31:0] exp_addr = '0;

    always #5 clk = ~clk;

    instr_encoder #(
        .FIFO_DEPTH (2),
        .ADDR_STEP  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rd         (rd),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct7     (funct7),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .imm_err    (imm_err),
        .word_count (word_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: head of the scoreboard must be presented (and held) while out_valid is high
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", out_instr, 32'hxxxx_xxxx);
            end else begin
                chk("out_instr", out_instr, sb[0][31:0]);
                chk("out_addr", out_addr, sb[0][63:32]);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    // Present one tuple (called just after a rising edge); returns after acceptance edge
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [6:0] f7, input logic [31:0] im,
                        input bit legal, input logic [31:0] exp_instr);
        int n;
        fmt = f; opcode = op; rd = d; funct3 = f3; rs1 = r1; rs2 = r2; funct7 = f7; imm = im;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("in_ready_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        if (in_ready && legal) begin
            sb.push_back({exp_addr, exp_instr});
            exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Pulse start for one cycle; expectations are dropped at the flushing edge
    task automatic do_start(input logic [31:0] base);
        base_addr = base;
        start = 1'b1;
        @(posedge clk);
        sb.delete();
        exp_addr = base;
        #1 start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_imm_err", 32'(imm_err), 32'd0);
        @(posedge clk); #1;

        // ---------------- basic encoding ----------------
        out_ready = 1'b1;
        do_start(32'h0000_0100);
        send(3'd0, 7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1, 32'h002081B3);
        @(negedge clk);
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        send(3'd1, 7'b0010011, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF, 1, 32'hFFF00293);
        send(3'd3, 7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC, 1, 32'hFE208EE3);
        // I out of range: rejected
        send(3'd1, 7'b0010011, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 0, 32'h0);
        @(negedge clk);
        chk("rej_imm_err", 32'(imm_err), 32'd1);
        chk("rej_word_count", 32'(word_count), 32'd3);
        @(posedge clk); #1;
        send(3'd2, 7'b0100011, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8, 1, 32'h0020A423);
        send(3'd4, 7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 1, 32'h123452B7);
        send(3'd5, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 1, 32'h001000EF);
        send(3'd1, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_F800, 1, 32'h80000093);
        send(3'd3, 7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4094, 1, 32'h7E000FE3);
        // more rejections: U low bits, odd B, illegal fmt, J just out of range, B below range
        send(3'd4, 7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345001, 0, 32'h0);
        send(3'd3, 7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3, 0, 32'h0);
        send(3'd6, 7'b0110011, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 32'd0, 0, 32'h0);
        send(3'd5, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0010_0000, 0, 32'h0);
        send(3'd3, 7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_EFFE, 0, 32'h0);
        wait_drain();
        chk("wc_after_mix", 32'(word_count), 32'd8);
        chk("err_sticky", 32'(imm_err), 32'd1);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        do_start(32'h0000_0100);
        @(negedge clk);
        chk("start_clr_err", 32'(imm_err), 32'd0);
        chk("start_clr_wc", 32'(word_count), 32'd0);
        @(posedge clk); #1;
        send(3'd0, 7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1, 32'h002081B3);
        send(3'd1, 7'b0010011, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF, 1, 32'hFFF00293);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        fork
            send(3'd4, 7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 1, 32'h123452B7);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_word_count", 32'(word_count), 32'd3);

        // ---------------- flush with start ----------------
        out_ready = 1'b0;
        do_start(32'h0000_0200);
        send(3'd7, 7'b0110011, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 32'd0, 0, 32'h0);
        send(3'd0, 7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1, 32'h002081B3);
        send(3'd0, 7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1, 32'h002081B3);
        do_start(32'hFFFF_FFFC);
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_wc", 32'(word_count), 32'd0);
        chk("flush_err", 32'(imm_err), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        // address wrap
        send(3'd1, 7'b0010011, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF, 1, 32'hFFF00293);
        send(3'd0, 7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1, 32'h002081B3);
        wait_drain();

        // ---------------- mid-stream reset overriding start ----------------
        out_ready = 1'b0;
        send(3'd0, 7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1, 32'h002081B3);
        send(3'd0, 7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1, 32'h002081B3);
        rst = 1'b1;
        start = 1'b1;
        base_addr = 32'h0000_0400;
        @(posedge clk);
        sb.delete();
        exp_addr = 32'h0;
        #1 rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_wc", 32'(word_count), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        // address after reset is zero, not base_addr
        send(3'd5, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 1, 32'h001000EF);
        wait_drain();
        chk("final_wc", 32'(word_count), 32'd1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_instr_encoder
`default_nettype wire
